// File: rtl/irq_cond_pkg.sv
// Shared constants and types for the interrupt input conditioner.
package irq_cond_pkg;

   localparam int IRQ_COND_MAX_CH  = 32;
   localparam int IRQ_COND_NUM_CH  = 32;
   localparam int IRQ_COND_DB_W    = 16;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } chan_state_e;

endpackage

// File: rtl/irq_cond_chan.sv
// One interrupt channel: two-flop synchronizer, saturating debounce counter,
// registered clean level and one-cycle change strobe.
module irq_cond_chan
   import irq_cond_pkg::*;
#(
   parameter int DB_W = IRQ_COND_DB_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            raw,
   input  logic [DB_W-1:0] db_limit,
   output logic            clean,
   output logic            pulse,
   output chan_state_e     state
);

   logic            s1;
   logic            s2;
   logic [DB_W-1:0] cnt;

   // The channel is pending exactly when the synchronized input disagrees
   // with the published level; no separate state register is needed.
   assign state = (s2 != clean) ? ST_PENDING : ST_STABLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         pulse <= 1'b0;
         case (state)
            ST_STABLE: cnt <= '0;
            ST_PENDING: begin
               // >= lets a lowered threshold fire at once; the counter only
               // advances while below the limit, so it can never wrap.
               if (cnt >= db_limit) begin
                  clean <= s2;
                  cnt   <= '0;
                  pulse <= 1'b1;
               end else begin
                  cnt <= cnt + DB_W'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: rtl/irq_input_conditioner.sv
// Synchronizes and debounces NUM_CH asynchronous interrupt sources.
// Optional IRQ_COND_INVERT_EN adds invert_mask to flip active-low sources.
module irq_input_conditioner
   import irq_cond_pkg::*;
#(
   parameter int NUM_CH = IRQ_COND_NUM_CH,
   parameter int DB_W   = IRQ_COND_DB_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] raw_in,
`ifdef IRQ_COND_INVERT_EN
   input  logic [NUM_CH-1:0] invert_mask,
`endif
   input  logic [DB_W-1:0]   db_limit,
   output logic [NUM_CH-1:0] clean_out,
   output logic [NUM_CH-1:0] change_pulse
);

   logic [NUM_CH-1:0] src;
   chan_state_e       chan_state [NUM_CH];

`ifdef IRQ_COND_INVERT_EN
   assign src = raw_in ^ invert_mask;
`else
   assign src = raw_in;
`endif

   generate
      if (NUM_CH < 1 || NUM_CH > IRQ_COND_MAX_CH) begin : g_bad_num_ch
         $error("irq_input_conditioner: NUM_CH out of range");
      end
   endgenerate

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      irq_cond_chan #(
         .DB_W (DB_W)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .raw      (src[i]),
         .db_limit (db_limit),
         .clean    (clean_out[i]),
         .pulse    (change_pulse[i]),
         .state    (chan_state[i])
      );
   end

endmodule
